// File: rtl/mire_gen_if.sv
// Wishbone B4 write-master bundle between mire_gen and the SDRAM arbiter.
interface mire_gen_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, we, sel, cyc, stb, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, we, sel, cyc, stb, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_gen.sv
// mire_gen: test-pattern generator writing full frames into the SDRAM frame buffer
// as incrementing Wishbone bursts, releasing the bus for GAP_CYC cycles between bursts.
// Optional feature macro: MIRE_SCROLL_EN (pattern scrolls left one pixel per frame).
module mire_gen #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned GRID      = 16,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter logic [23:0] SOLID_COL = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  mire_gen_if.master  wb,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     fcnt_q, fcnt_d;
  logic            fdone_q, fdone_d;
  logic            cyc_q, cyc_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [2:0]      cti_q, cti_d;

  logic            start;
  logic            adv;
  logic [XW-1:0]   xs;
  logic [2:0]      bar;
  logic [23:0]     pix;

  // Colour of one of the eight vertical bars, left to right.
  function automatic logic [23:0] bar_col(input logic [2:0] b);
    case (b)
      3'd0:    bar_col = 24'hFFFFFF;
      3'd1:    bar_col = 24'hFFFF00;
      3'd2:    bar_col = 24'h00FFFF;
      3'd3:    bar_col = 24'h00FF00;
      3'd4:    bar_col = 24'hFF00FF;
      3'd5:    bar_col = 24'hFF0000;
      3'd6:    bar_col = 24'h0000FF;
      default: bar_col = 24'h000000;
    endcase
  endfunction

  // State, counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      mode_q  <= 2'd0;
      fcnt_q  <= 16'd0;
      fdone_q <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= BASE_ADR;
      dat_q   <= 32'd0;
      cti_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      fdone_q <= fdone_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cti_q   <= cti_d;
    end
  end

  // Burst sequencing, pixel counters and next-beat address/data/cti.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    mode_d  = mode_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    start   = 1'b0;
    adv     = 1'b0;

    case (state_q)
      IDLE:  start = enable;
      BURST: adv = cyc_q & wb.ack;
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          if (enable) start = 1'b1;
          else        state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A burst starting on pixel (0,0) is a frame start: latch the pattern there only.
    if (start) begin
      state_d = BURST;
      cyc_d   = 1'b1;
      if (x_q == '0 && y_q == '0) mode_d = mode;
    end

    if (adv) begin
      if (x_q == XW'(HDISP - 1)) begin
        x_d = '0;
        if (y_q == YW'(VDISP - 1)) begin
          y_d     = '0;
          fdone_d = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
      if (beat_q == BW'(BURST_LEN - 1)) begin
        beat_d  = '0;
        state_d = GAP;
        gap_d   = '0;
        cyc_d   = 1'b0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

`ifdef MIRE_SCROLL_EN
    xs = XW'((32'(x_d) + 32'(fcnt_d)) % 32'(HDISP));
`else
    xs = x_d;
`endif
    bar = 3'((32'(xs) * 32'd8) / 32'(HDISP));
    case (mode_d)
      2'd0: pix = (((32'(xs) & 32'(GRID - 1)) == 32'd0) ||
                   ((32'(y_d) & 32'(GRID - 1)) == 32'd0)) ? 24'hFFFFFF : 24'h000000;
      2'd1: pix = bar_col(bar);
      2'd2: pix = {3{8'(xs)}};
      default: pix = SOLID_COL;
    endcase

    // Beat outputs only change when a new beat is presented, so they hold during stalls.
    if (start || adv) begin
      adr_d = BASE_ADR + ((32'(y_d) * 32'(HDISP) + 32'(x_d)) << 2);
      dat_d = {8'h00, pix};
      cti_d = (beat_d == BW'(BURST_LEN - 1)) ? 3'b111 : 3'b010;
    end
  end

  assign wb.adr     = adr_q;
  assign wb.dat_ms  = dat_q;
  assign wb.we      = 1'b1;
  assign wb.sel     = 4'b1111;
  assign wb.cyc     = cyc_q;
  assign wb.stb     = cyc_q;
  assign wb.cti     = cti_q;
  assign wb.bte     = 2'b00;
  assign frame_done = fdone_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_mire_gen.sv
// Directed bench for mire_gen with a beat scoreboard and a Wishbone slave model.
module tb_mire_gen;
  localparam int unsigned HDISP = 800;
  localparam int unsigned VDISP = 4;
  localparam int unsigned BL    = 16;
  localparam int unsigned GAPC  = 4;
  localparam int unsigned GRID  = 16;
  localparam int unsigned NPIX  = HDISP * VDISP;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [23:0] SOLID = 24'h0000FF;
`ifdef MIRE_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic        frame_done;
  logic [15:0] frame_cnt;

  mire_gen_if wb ();

  mire_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST_LEN(BL), .GAP_CYC(GAPC), .GRID(GRID),
    .BASE_ADR(BASE), .SOLID_COL(SOLID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .wb(wb),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       q[$];
  int          checks, errors;
  int          mx, my, mb, mfc;
  logic [1:0]  mmode;
  bit          exp_fd;
  int          fd_count, acks, stall, gap_run, last_gap, cyc_hi, hold;
  bit          stall_en;
  logic [31:0] pix_mem [NPIX];
  logic [2:0]  cti_log [32];
  logic [31:0] last_adr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int xs, input int y, input logic [1:0] m);
    logic [7:0] v;
    int b;
    v = 8'(xs);
    b = (xs * 8) / int'(HDISP);
    case (m)
      2'd0: return ((xs % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
      2'd1: case (b)
              0: return 24'hFFFFFF;
              1: return 24'hFFFF00;
              2: return 24'h00FFFF;
              3: return 24'h00FF00;
              4: return 24'hFF00FF;
              5: return 24'hFF0000;
              6: return 24'h0000FF;
              default: return 24'h000000;
            endcase
      2'd2: return {v, v, v};
      default: return SOLID;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    mx = 0; my = 0; mb = 0; mfc = 0; mmode = 2'd0;
    exp_fd = 1'b0; acks = 0; stall = 0;
  endtask

  // Expected next beat from the bench's own pixel walk.
  task automatic model_push();
    beat_t b;
    int    xs;
    if (mx == 0 && my == 0) mmode = mode;
    xs     = SCROLL ? (mx + mfc) % int'(HDISP) : mx;
    b.adr  = BASE + 32'((my * int'(HDISP) + mx) * 4);
    b.dat  = {8'h00, exp_pix(xs, my, mmode)};
    b.cti  = (mb == int'(BL) - 1) ? 3'b111 : 3'b010;
    b.last = (mx == int'(HDISP) - 1) && (my == int'(VDISP) - 1);
    q.push_back(b);
    mb = (mb + 1) % int'(BL);
    if (mx == int'(HDISP) - 1) begin
      mx = 0;
      my = (my == int'(VDISP) - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  // One cycle: check outputs at negedge, then drive ack for the coming edge.
  task automatic tick();
    int idx;
    @(negedge clk);
    if (!rst_n) begin
      wb.ack = 1'b0;
      return;
    end
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (frame_done) begin
      fd_count++;
      chk("frame_cnt", 32'(frame_cnt), 32'(mfc));
    end
    exp_fd = 1'b0;
    if (wb.cyc) begin
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
      cyc_hi++;
    end else begin
      gap_run++;
    end
    if (wb.stb) begin
      if (q.size() == 0) model_push();
      chk("adr", wb.adr, q[0].adr);
      chk("dat", wb.dat_ms, q[0].dat);
      chk("cti", 32'(wb.cti), 32'(q[0].cti));
      if (stall_en && stall > 0) begin
        wb.ack = 1'b0;
        stall--;
      end else begin
        wb.ack = 1'b1;
        stall  = stall_en ? int'($urandom_range(0, 5)) : 0;
        idx    = int'((wb.adr - BASE) >> 2);
        if (idx >= 0 && idx < int'(NPIX)) pix_mem[idx] = wb.dat_ms;
        if (acks < 32) cti_log[acks] = wb.cti;
        last_adr = wb.adr;
        if (q[0].last) begin
          exp_fd = 1'b1;
          mfc    = (mfc + 1) % 65536;
        end
        void'(q.pop_front());
        acks++;
      end
    end else begin
      wb.ack = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic run_acks(input int target, input int budget);
    int n;
    n = 0;
    while (acks < target && n < budget) begin
      tick();
      n++;
    end
    chk("ack_budget", 32'(acks >= target), 32'd1);
  endtask

  task automatic run_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_count < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_budget", 32'(fd_count >= target), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    chk("rst_stb", 32'(wb.stb), 32'd0);
    chk("rst_adr", wb.adr, BASE);
    chk("rst_dat", wb.dat_ms, 32'd0);
    chk("rst_cti", 32'(wb.cti), 32'b010);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; fd_count = 0; gap_run = 0; last_gap = 0; cyc_hi = 0;
    last_adr = 32'hFFFF_FFFF; stall_en = 1'b0;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; wb.ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    chk("we", 32'(wb.we), 32'd1);
    chk("sel", 32'(wb.sel), 32'hF);
    chk("bte", 32'(wb.bte), 32'd0);

    // Zero-wait slave, grid pattern, first two bursts.
    rst_n = 1'b1; enable = 1'b1; mode = 2'd0;
    run_acks(17, 200);
    chk("first_adr", pix_mem[0] === 32'h00FFFFFF ? 32'd0 : 32'd1, 32'd0);
    chk("beat1_white", pix_mem[1], 32'h00FFFFFF);
    chk("cti_beat14", 32'(cti_log[14]), 32'b010);
    chk("cti_beat15", 32'(cti_log[15]), 32'b111);
    chk("burst1_adr", last_adr, BASE + 32'd64);
    chk("gap_len", 32'(last_gap), 32'(GAPC));

    // Random stalls through the end of frame 0.
    stall_en = 1'b1;
    run_fd(1, 40000);
    chk("frame0_acks", 32'(acks), 32'(NPIX));
    chk("frame0_cnt", 32'(frame_cnt), 32'd1);

    // Frame 1 in ramp mode; switch to bars mid-frame.
    stall_en = 1'b0; stall = 0; mode = 2'd2;
    run_acks(int'(NPIX) + 1, 100);
    chk("ramp_f1_x0", pix_mem[0], SCROLL ? 32'h00010101 : 32'h00000000);
    run_acks(int'(NPIX) + int'(NPIX) / 2, 4000);
    mode = 2'd1;
    run_fd(2, 6000);
    chk("ramp_f1_tail", pix_mem[3 * HDISP + 5], SCROLL ? 32'h00060606 : 32'h00050505);
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

    // Frame 2 in bars.
    run_fd(3, 6000);
    chk("bars_f2_x0", pix_mem[0], 32'h00FFFFFF);
    chk("bars_y1_x99", pix_mem[HDISP + 99], SCROLL ? 32'h00FFFF00 : 32'h00FFFFFF);
    chk("bars_y1_x100", pix_mem[HDISP + 100], 32'h00FFFF00);
    chk("bars_y1_x799", pix_mem[HDISP + 799], SCROLL ? 32'h00FFFFFF : 32'h00000000);

    // Drop enable while beat 5 of a burst is presented.
    run_acks(3 * int'(NPIX) + 53, 200);
    enable = 1'b0;
    repeat (60) tick();
    chk("burst_completed", 32'(acks), 32'(3 * NPIX + 64));
    chk("burst_last_cti", 32'(cti_log[15]), 32'b111);
    hold = cyc_hi;
    repeat (20) tick();
    chk("idle_no_cyc", 32'(cyc_hi), 32'(hold));
    enable = 1'b1;
    run_acks(3 * int'(NPIX) + 65, 100);
    chk("resume_adr", last_adr, BASE + 32'd256);

    // Reset in the middle of a stalled burst.
    stall_en = 1'b1;
    run_acks(3 * int'(NPIX) + 71, 500);
    @(negedge clk);
    rst_n = 1'b0; wb.ack = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    model_reset();
    stall_en = 1'b0; mode = 2'd3;
    @(negedge clk);
    rst_n = 1'b1;
    run_acks(1, 50);
    chk("restart_adr", last_adr, BASE);
    chk("restart_solid", pix_mem[0], 32'h000000FF);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
